// File: rtl/dds_wave_gen.sv
// dds_wave_gen
//   8-bit direct digital synthesis source programmed with a 4-digit BCD
//   frequency (0..9999 Hz). A request is taken over a valid/ready
//   handshake. It is converted to binary one digit per cycle, scaled to a
//   frequency tuning word (ftw) and committed to a free-running phase
//   accumulator. The top 8 phase bits address four registered waveform
//   generators and a registered selectable output.
//
// Handshake: a request transfers on a rising edge where set_valid and
//   set_ready are both high. set_ready is high only while the converter is
//   idle. set_valid is ignored at all other times, and the digit inputs may
//   change freely once the transfer has happened.
//
// Ports
//   clk           in   1  system clock, rising edge
//   rst_n         in   1  asynchronous active-low reset
//   set_valid     in   1  new frequency request
//   set_ready     out  1  converter idle, request can transfer
//   fre_set_thou  in   4  BCD thousands digit
//   fre_set_hund  in   4  BCD hundreds digit
//   fre_set_ten   in   4  BCD tens digit
//   fre_set_one   in   4  BCD ones digit
//   set_done      out  1  one-cycle pulse, new ftw committed
//   set_err       out  1  one-cycle pulse, request rejected (a digit > 9)
//   wave_sel      in   2  00 sine, 01 square, 10 triangle, 11 sawtooth
//   DAC_sin       out  8  sine code, midscale 128
//   DAC_squ       out  8  square code, 0 or 255
//   DAC_tri       out  8  triangle code
//   DAC_saw       out  8  sawtooth code
//   wave_out      out  8  code picked by wave_sel
module dds_wave_gen #(
    parameter int ACC_W     = 32,
    parameter int FTW_MUL   = 21990,
    parameter int FTW_SHIFT = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       set_valid,
    output logic       set_ready,
    input  logic [3:0] fre_set_thou,
    input  logic [3:0] fre_set_hund,
    input  logic [3:0] fre_set_ten,
    input  logic [3:0] fre_set_one,
    output logic       set_done,
    output logic       set_err,
    input  logic [1:0] wave_sel,
    output logic [7:0] DAC_sin,
    output logic [7:0] DAC_squ,
    output logic [7:0] DAC_tri,
    output logic [7:0] DAC_saw,
    output logic [7:0] wave_out
);

    // 9999 needs 14 bits; 9999 * 21990 needs 28, so 29 bits leaves margin.
    localparam int BIN_W  = 14;
    localparam int PROD_W = 29;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CONV   = 2'd1,
        S_SCALE  = 2'd2,
        S_COMMIT = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [15:0]       digits;
    logic [1:0]        conv_cnt;
    logic [BIN_W-1:0]  bin_hz;
    logic [ACC_W-1:0]  ftw_new;
    logic [ACC_W-1:0]  ftw;
    logic [ACC_W-1:0]  phase;

    logic              transfer;
    logic              digit_bad;
    logic [3:0]        cur_digit;
    logic [BIN_W-1:0]  bin_mac;
    logic [PROD_W-1:0] prod;

    logic [7:0] p;
    logic [5:0] sin_idx;
    logic [6:0] sin_q;
    logic [7:0] sin_next;
    logic [7:0] squ_next;
    logic [7:0] tri_next;
    logic [7:0] saw_next;
    logic [7:0] sel_next;

    // ------------------------------------------------------------------
    // Handshake and request decode
    // ------------------------------------------------------------------
    assign set_ready = (state == S_IDLE);
    assign transfer  = set_valid && set_ready;

    // Checked on the raw inputs so the reject decision is made on the
    // same edge that latches the digits.
    assign digit_bad = (fre_set_thou > 4'd9) || (fre_set_hund > 4'd9) ||
                       (fre_set_ten  > 4'd9) || (fre_set_one  > 4'd9);

    // Most significant digit first: conv_cnt 0 picks the thousands digit.
    always_comb begin
        cur_digit = 4'd0;
        case (conv_cnt)
            2'd0: cur_digit = digits[15:12];
            2'd1: cur_digit = digits[11:8];
            2'd2: cur_digit = digits[7:4];
            2'd3: cur_digit = digits[3:0];
            default: cur_digit = 4'd0;
        endcase
    end

    assign bin_mac = bin_hz * 14'd10 + {10'd0, cur_digit};
    assign prod    = PROD_W'(bin_hz) * PROD_W'(FTW_MUL);

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (transfer && !digit_bad) begin
                    state_next = S_CONV;
                end
            end
            S_CONV: begin
                if (conv_cnt == 2'd3) begin
                    state_next = S_SCALE;
                end
            end
            S_SCALE:  state_next = S_COMMIT;
            S_COMMIT: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Conversion datapath and status pulses
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits   <= '0;
            conv_cnt <= '0;
            bin_hz   <= '0;
            ftw_new  <= '0;
            ftw      <= '0;
            set_done <= 1'b0;
            set_err  <= 1'b0;
        end else begin
            set_done <= 1'b0;
            set_err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (transfer) begin
                        digits <= {fre_set_thou, fre_set_hund, fre_set_ten, fre_set_one};
                        if (digit_bad) begin
                            set_err <= 1'b1;
                        end else begin
                            bin_hz   <= '0;
                            conv_cnt <= '0;
                        end
                    end
                end
                S_CONV: begin
                    bin_hz   <= bin_mac;
                    conv_cnt <= conv_cnt + 2'd1;
                end
                S_SCALE: begin
                    ftw_new <= ACC_W'(prod >> FTW_SHIFT);
                end
                S_COMMIT: begin
                    ftw      <= ftw_new;
                    set_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Phase accumulator: never reset on a frequency change, so the output
    // stays phase-continuous. ftw = 0 simply freezes it.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= '0;
        end else begin
            phase <= phase + ftw;
        end
    end

    // ------------------------------------------------------------------
    // Waveform generators
    // ------------------------------------------------------------------
    // Quarter-wave sine table sampled at the centre of each step, so the
    // mirrored quadrants meet without a repeated code at the fold points.
    function automatic logic [6:0] quarter_sin(input logic [5:0] i);
        quarter_sin = 7'd0;
        case (i)
            6'd0:  quarter_sin = 7'd2;    6'd1:  quarter_sin = 7'd5;
            6'd2:  quarter_sin = 7'd8;    6'd3:  quarter_sin = 7'd11;
            6'd4:  quarter_sin = 7'd14;   6'd5:  quarter_sin = 7'd17;
            6'd6:  quarter_sin = 7'd20;   6'd7:  quarter_sin = 7'd23;
            6'd8:  quarter_sin = 7'd26;   6'd9:  quarter_sin = 7'd29;
            6'd10: quarter_sin = 7'd32;   6'd11: quarter_sin = 7'd35;
            6'd12: quarter_sin = 7'd38;   6'd13: quarter_sin = 7'd41;
            6'd14: quarter_sin = 7'd44;   6'd15: quarter_sin = 7'd47;
            6'd16: quarter_sin = 7'd50;   6'd17: quarter_sin = 7'd53;
            6'd18: quarter_sin = 7'd56;   6'd19: quarter_sin = 7'd58;
            6'd20: quarter_sin = 7'd61;   6'd21: quarter_sin = 7'd64;
            6'd22: quarter_sin = 7'd67;   6'd23: quarter_sin = 7'd69;
            6'd24: quarter_sin = 7'd72;   6'd25: quarter_sin = 7'd74;
            6'd26: quarter_sin = 7'd77;   6'd27: quarter_sin = 7'd79;
            6'd28: quarter_sin = 7'd82;   6'd29: quarter_sin = 7'd84;
            6'd30: quarter_sin = 7'd86;   6'd31: quarter_sin = 7'd89;
            6'd32: quarter_sin = 7'd91;   6'd33: quarter_sin = 7'd93;
            6'd34: quarter_sin = 7'd95;   6'd35: quarter_sin = 7'd97;
            6'd36: quarter_sin = 7'd99;   6'd37: quarter_sin = 7'd101;
            6'd38: quarter_sin = 7'd103;  6'd39: quarter_sin = 7'd105;
            6'd40: quarter_sin = 7'd106;  6'd41: quarter_sin = 7'd108;
            6'd42: quarter_sin = 7'd110;  6'd43: quarter_sin = 7'd111;
            6'd44: quarter_sin = 7'd113;  6'd45: quarter_sin = 7'd114;
            6'd46: quarter_sin = 7'd115;  6'd47: quarter_sin = 7'd117;
            6'd48: quarter_sin = 7'd118;  6'd49: quarter_sin = 7'd119;
            6'd50: quarter_sin = 7'd120;  6'd51: quarter_sin = 7'd121;
            6'd52: quarter_sin = 7'd122;  6'd53: quarter_sin = 7'd123;
            6'd54: quarter_sin = 7'd124;  6'd55: quarter_sin = 7'd124;
            6'd56: quarter_sin = 7'd125;  6'd57: quarter_sin = 7'd125;
            6'd58: quarter_sin = 7'd126;  6'd59: quarter_sin = 7'd126;
            6'd60: quarter_sin = 7'd127;  6'd61: quarter_sin = 7'd127;
            6'd62: quarter_sin = 7'd127;  6'd63: quarter_sin = 7'd127;
            default: quarter_sin = 7'd0;
        endcase
    endfunction

    assign p = phase[ACC_W-1 -: 8];

    // p[6] selects the falling half of each half-cycle (mirror the index),
    // p[7] selects the negative half (mirror about midscale).
    assign sin_idx  = p[6] ? ~p[5:0] : p[5:0];
    assign sin_q    = quarter_sin(sin_idx);
    assign sin_next = p[7] ? (8'd128 - {1'b0, sin_q}) : (8'd128 + {1'b0, sin_q});
    assign squ_next = p[7] ? 8'd255 : 8'd0;
    assign tri_next = p[7] ? ~{p[6:0], 1'b0} : {p[6:0], 1'b0};
    assign saw_next = p;

    always_comb begin
        sel_next = sin_next;
        case (wave_sel)
            2'b00: sel_next = sin_next;
            2'b01: sel_next = squ_next;
            2'b10: sel_next = tri_next;
            2'b11: sel_next = saw_next;
            default: sel_next = sin_next;
        endcase
    end

    // All codes register from the same phase sample, so wave_out always
    // matches the selected DAC output of the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            DAC_sin  <= 8'd128;
            DAC_squ  <= 8'd0;
            DAC_tri  <= 8'd0;
            DAC_saw  <= 8'd0;
            wave_out <= 8'd0;
        end else begin
            DAC_sin  <= sin_next;
            DAC_squ  <= squ_next;
            DAC_tri  <= tri_next;
            DAC_saw  <= saw_next;
            wave_out <= sel_next;
        end
    end

endmodule
